// File: rtl/jpeg_chan_sched_pkg.sv
// Purpose: shared types and constants for the JPEG channel scheduler and the encoder datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scheduler FSM state enum, channel codes, default geometry and counter widths.
package jpeg_chan_sched_pkg;

  // Default block geometry and core latency.
  localparam int NPIX_DEF     = 64;
  localparam int CORE_LAT_DEF = 4;

  // Address into the upstream block buffer, and internal counter widths.
  // The LOAD counter carries one spare bit so that the comparison against
  // NPIX-1 never aliases.
  localparam int ADDR_W = 6;
  localparam int LCNT_W = 7;
  localparam int WCNT_W = 4;
  localparam int BCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  // Channel codes as presented on chan_sel; code 3 is never driven.
  localparam logic [1:0] CH_Y  = 2'd0;
  localparam logic [1:0] CH_CB = 2'd1;
  localparam logic [1:0] CH_CR = 2'd2;

  // Channel that follows ch within one block (only called for Y and Cb).
  function automatic logic [1:0] next_chan(input logic [1:0] ch);
    return ch + 2'd1;
  endfunction

endpackage

// File: rtl/jpeg_sched_cnt.sv
// Purpose: loadable up-counter with a terminal-count flag.
// Latency: count updates one cycle after load_i/en_i; term_o is a compare on the registered count.
// Backpressure: none; the count holds whenever en_i is low.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i/load_val_i synchronous load
//        (wins over en_i); en_i increment; last_i terminal value; cnt_o count; term_o cnt_o==last_i.
module jpeg_sched_cnt #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == last_i);

endmodule

// File: rtl/jpeg_chan_sched.sv
// Purpose: sequences Y, Cb, Cr of one buffered 8x8 block through a shared encoder core.
// Latency: 3*(NPIX+CORE_LAT+1) cycles from acceptance to the last DRAIN cycle with res_ready_i held high.
// Backpressure: DRAIN holds res_valid_o and the channel until res_ready_i; blk_ready_o only in IDLE.
// Ports: clock_i/reset_n_i clock and async active-low reset; blk_valid_i/blk_ready_o block handshake;
//        rd_addr_o pixel index; chan_sel_o channel; core_input_enable_o/core_output_enable_o core controls;
//        res_valid_o/res_ready_i result handshake; blk_done_o completion pulse; blk_cnt_o completed blocks.
module jpeg_chan_sched
  import jpeg_chan_sched_pkg::*;
#(
  parameter int NPIX     = NPIX_DEF,
  parameter int CORE_LAT = CORE_LAT_DEF
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              blk_valid_i,
  output logic              blk_ready_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [1:0]        chan_sel_o,
  output logic              core_input_enable_o,
  output logic              core_output_enable_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              blk_done_o,
  output logic [BCNT_W-1:0] blk_cnt_o
);

  localparam logic [LCNT_W-1:0] LD_LAST = LCNT_W'(NPIX - 1);
  // With no core latency the WAIT counter is never consulted; any value will do.
  localparam logic [WCNT_W-1:0] WT_LAST = (CORE_LAT == 0) ? '0 : WCNT_W'(CORE_LAT - 1);

  sched_state_e      state_q;
  logic              blk_ready_q;
  logic [1:0]        chan_sel_q;
  logic              cie_q;
  logic              coe_q;
  logic              res_valid_q;
  logic              blk_done_q;
  logic [BCNT_W-1:0] blk_cnt_q;

  logic              ld_load;
  logic              ld_en;
  logic              ld_term;
  logic [LCNT_W-1:0] ld_cnt;
  logic              wt_load;
  logic              wt_en;
  logic              wt_term;
  logic [WCNT_W-1:0] unused_wt_cnt;
  logic              unused_ld_msb;

  // LOAD counter doubles as the registered read address. It is held at zero
  // in IDLE and rewound when a result is accepted, and it freezes at NPIX-1
  // through WAIT and DRAIN so the address never runs past the block.
  assign ld_load = (state_q == ST_IDLE) || ((state_q == ST_DRAIN) && res_ready_i);
  assign ld_en   = (state_q == ST_LOAD) && !ld_term;

  // WAIT counter sits at zero outside WAIT, so every WAIT visit lasts exactly CORE_LAT cycles.
  assign wt_load = (state_q != ST_WAIT);
  assign wt_en   = (state_q == ST_WAIT) && !wt_term;

  jpeg_sched_cnt #(.W(LCNT_W)) u_load_cnt (
    .clk_i      (clock_i),
    .rst_ni     (reset_n_i),
    .load_i     (ld_load),
    .load_val_i ('0),
    .en_i       (ld_en),
    .last_i     (LD_LAST),
    .cnt_o      (ld_cnt),
    .term_o     (ld_term)
  );

  jpeg_sched_cnt #(.W(WCNT_W)) u_wait_cnt (
    .clk_i      (clock_i),
    .rst_ni     (reset_n_i),
    .load_i     (wt_load),
    .load_val_i ('0),
    .en_i       (wt_en),
    .last_i     (WT_LAST),
    .cnt_o      (unused_wt_cnt),
    .term_o     (wt_term)
  );

  assign unused_ld_msb = ld_cnt[LCNT_W-1];

  // Every control output is set on the transition into the state that owns
  // it, so all outputs are flops and none follows an input combinationally.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      blk_ready_q <= 1'b1;
      chan_sel_q  <= CH_Y;
      cie_q       <= 1'b0;
      coe_q       <= 1'b0;
      res_valid_q <= 1'b0;
      blk_done_q  <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      blk_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (blk_valid_i) begin
            state_q     <= ST_LOAD;
            blk_ready_q <= 1'b0;
            chan_sel_q  <= CH_Y;
            cie_q       <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_term) begin
            cie_q <= 1'b0;
            if (CORE_LAT == 0) begin
              state_q     <= ST_DRAIN;
              res_valid_q <= 1'b1;
              coe_q       <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wt_term) begin
            state_q     <= ST_DRAIN;
            res_valid_q <= 1'b1;
            coe_q       <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            coe_q       <= 1'b0;
            if (chan_sel_q != CH_CR) begin
              state_q    <= ST_LOAD;
              chan_sel_q <= next_chan(chan_sel_q);
              cie_q      <= 1'b1;
            end else begin
              // Completion is reported together with the return to IDLE; the
              // count wraps naturally at the top of its range.
              state_q     <= ST_IDLE;
              blk_ready_q <= 1'b1;
              chan_sel_q  <= CH_Y;
              blk_done_q  <= 1'b1;
              blk_cnt_q   <= blk_cnt_q + BCNT_W'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          blk_ready_q <= 1'b1;
          chan_sel_q  <= CH_Y;
          cie_q       <= 1'b0;
          coe_q       <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign blk_ready_o          = blk_ready_q;
  assign rd_addr_o            = ld_cnt[ADDR_W-1:0];
  assign chan_sel_o           = chan_sel_q;
  assign core_input_enable_o  = cie_q;
  assign core_output_enable_o = coe_q;
  assign res_valid_o          = res_valid_q;
  assign blk_done_o           = blk_done_q;
  assign blk_cnt_o            = blk_cnt_q;

endmodule
